pcs_rx_link_ctrl: RTL and testbench

//  Link bring-up sequencer for the PCS RX datapath. Watches SerDes lock, per-lane block sync lock,
//  per-lane alignment-marker lock and deskew lock. Steps through the bring-up states in order.

---
 rtl/pcs_rx_ctrl_pkg.sv | 22 ++
 rtl/pcs_rx_ber_mon.sv | 57 +++++
 rtl/pcs_rx_link_ctrl.sv | 128 ++++++++++++
 tb/tb_pcs_rx_link_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/pcs_rx_ctrl_pkg.sv
// Shared types and default constants for the PCS RX link bring-up sequencer.
package pcs_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESTART     = 3'd0,
    ST_WAIT_SERDES = 3'd1,
    ST_WAIT_BLOCK  = 3'd2,
    ST_WAIT_AM     = 3'd3,
    ST_WAIT_DESKEW = 3'd4,
    ST_LINK_UP     = 3'd5
  } state_e;

  localparam int RESTART_CNT_W   = 8;
  localparam int DEF_TIMER_W     = 20;
  localparam int DEF_BLOCK_TO    = 2**16;
  localparam int DEF_AM_TO       = 2**18;
  localparam int DEF_DESKEW_TO   = 2**12;
  localparam int DEF_RESTART_CYC = 16;
  localparam int DEF_BER_WIN     = 2**17;
  localparam int DEF_HI_BER_CNT  = 97;

endpackage

// File: rtl/pcs_rx_ber_mon.sv
// Sync-header error monitor: counts invalid headers per window and raises hi_ber
// when a window accumulates HI_BER_CNT of them. Cleared whenever en is low.
module pcs_rx_ber_mon #(
  parameter int LANE_N     = 4,
  parameter int BER_WIN    = 2**17,
  parameter int HI_BER_CNT = 97
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [LANE_N-1:0] head_v,
  input  logic [LANE_N-1:0] head_err,
  output logic              hi_ber,
  output logic              win_wrap
);
  localparam int WIN_W = $clog2(BER_WIN);
  localparam int ERR_W = $clog2(HI_BER_CNT + 1);
  localparam int SUM_W = ERR_W + $clog2(LANE_N + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_TH  = ERR_W'(HI_BER_CNT);

  logic [WIN_W-1:0] r_win;
  logic [ERR_W-1:0] r_err;
  logic             r_hi_ber;
  logic [SUM_W-1:0] w_pop, w_sum_full;
  logic [ERR_W-1:0] w_pop_sat, w_sum;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < LANE_N; i++)
      w_pop = w_pop + SUM_W'(head_v[i] & head_err[i]);
    w_sum_full = SUM_W'(r_err) + w_pop;
    w_pop_sat  = (w_pop > SUM_W'(ERR_MAX)) ? ERR_MAX : w_pop[ERR_W-1:0];
    w_sum      = (w_sum_full > SUM_W'(ERR_MAX)) ? ERR_MAX : w_sum_full[ERR_W-1:0];
  end

  assign win_wrap = en & (r_win == WIN_W'(BER_WIN - 1));
  assign hi_ber   = r_hi_ber & en;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      r_win    <= '0;
      r_err    <= '0;
      r_hi_ber <= 1'b0;
    end else if (win_wrap) begin
      // New window starts with the wrap-cycle errors; flag survives only a bad window
      r_win    <= '0;
      r_err    <= w_pop_sat;
      r_hi_ber <= (w_sum >= ERR_TH);
    end else begin
      r_win <= r_win + 1'b1;
      r_err <= w_sum;
      if (w_sum >= ERR_TH) r_hi_ber <= 1'b1;
    end
  end

endmodule

// File: rtl/pcs_rx_link_ctrl.sv
// PCS RX link bring-up sequencer: serdes -> block sync -> AM -> deskew -> link up,
// restarting lanes on timeout or lock loss. PCS_RX_LINK_CTRL_BER_RESTART_EN adds hi_ber restart.
module pcs_rx_link_ctrl
  import pcs_rx_ctrl_pkg::*;
#(
  parameter int LANE_N      = 4,
  parameter int TIMER_W     = DEF_TIMER_W,
  parameter int BLOCK_TO    = DEF_BLOCK_TO,
  parameter int AM_TO       = DEF_AM_TO,
  parameter int DESKEW_TO   = DEF_DESKEW_TO,
  parameter int RESTART_CYC = DEF_RESTART_CYC,
  parameter int BER_WIN     = DEF_BER_WIN,
  parameter int HI_BER_CNT  = DEF_HI_BER_CNT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LANE_N-1:0]        serdes_lock_v_i,
  input  logic [LANE_N-1:0]        bs_lock_v_i,
  input  logic [LANE_N-1:0]        am_lock_v_i,
  input  logic                     deskew_lock_v_i,
  input  logic [LANE_N-1:0]        head_v_i,
  input  logic [LANE_N-1:0]        head_err_i,
  output logic [LANE_N-1:0]        lane_rst_o,
  output logic                     deskew_rst_o,
  output logic                     link_up_o,
  output logic                     hi_ber_o,
  output logic [2:0]               state_o,
  output logic [RESTART_CNT_W-1:0] restart_cnt_o
);
  localparam int HOLD_W = $clog2(RESTART_CYC);

  state_e                   r_state, w_nxt, w_adv_st;
  logic [HOLD_W-1:0]        r_hold;
  logic [TIMER_W-1:0]       r_timer;
  logic [RESTART_CNT_W-1:0] r_restart_cnt;
  logic [LANE_N-1:0]        r_lane_rst;
  logic                     r_deskew_rst;
  logic                     w_loss, w_to, w_adv, w_ber_en, w_hi_ber, w_win_wrap;
  logic                     w_serdes_ok, w_bs_ok, w_am_ok, w_stage;

  assign w_serdes_ok = &serdes_lock_v_i;
  assign w_bs_ok     = &bs_lock_v_i;
  assign w_am_ok     = &am_lock_v_i;
  assign w_ber_en    = (r_state == ST_LINK_UP);
  assign w_stage     = (r_state == ST_WAIT_BLOCK) || (r_state == ST_WAIT_AM) ||
                       (r_state == ST_WAIT_DESKEW);

  pcs_rx_ber_mon #(.LANE_N(LANE_N), .BER_WIN(BER_WIN), .HI_BER_CNT(HI_BER_CNT)) u_ber_mon (
    .clk(clk), .reset(reset), .en(w_ber_en), .head_v(head_v_i), .head_err(head_err_i),
    .hi_ber(w_hi_ber), .win_wrap(w_win_wrap)
  );

  // Each state contributes a lock-loss, timeout and advance term; loss > timeout > advance
  always_comb begin
    w_loss   = 1'b0;
    w_to     = 1'b0;
    w_adv    = 1'b0;
    w_adv_st = r_state;
    case (r_state)
      ST_RESTART: begin
        w_adv = (r_hold == HOLD_W'(RESTART_CYC - 1)); w_adv_st = ST_WAIT_SERDES;
      end
      ST_WAIT_SERDES: begin
        w_adv = w_serdes_ok; w_adv_st = ST_WAIT_BLOCK;
      end
      ST_WAIT_BLOCK: begin
        w_loss = ~w_serdes_ok;
        w_to   = (r_timer == TIMER_W'(BLOCK_TO - 1));
        w_adv  = w_bs_ok; w_adv_st = ST_WAIT_AM;
      end
      ST_WAIT_AM: begin
        w_loss = ~(w_serdes_ok & w_bs_ok);
        w_to   = (r_timer == TIMER_W'(AM_TO - 1));
        w_adv  = w_am_ok; w_adv_st = ST_WAIT_DESKEW;
      end
      ST_WAIT_DESKEW: begin
        w_loss = ~(w_serdes_ok & w_bs_ok & w_am_ok);
        w_to   = (r_timer == TIMER_W'(DESKEW_TO - 1));
        w_adv  = deskew_lock_v_i; w_adv_st = ST_LINK_UP;
      end
      ST_LINK_UP: begin
        w_loss = ~(w_serdes_ok & w_bs_ok & w_am_ok & deskew_lock_v_i);
`ifdef PCS_RX_LINK_CTRL_BER_RESTART_EN
        w_to   = w_hi_ber & w_win_wrap;
`endif
      end
      default: w_loss = 1'b1;
    endcase
    w_nxt = (w_loss || w_to) ? ST_RESTART : (w_adv ? w_adv_st : r_state);
  end

`ifndef PCS_RX_LINK_CTRL_BER_RESTART_EN
  logic w_unused_wrap;
  assign w_unused_wrap = w_win_wrap;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RESTART;
      r_hold        <= '0;
      r_timer       <= '0;
      r_restart_cnt <= '0;
      r_lane_rst    <= '1;
      r_deskew_rst  <= 1'b1;
    end else begin
      r_state <= w_nxt;
      r_hold  <= (r_state == ST_RESTART && w_nxt == ST_RESTART) ? r_hold + 1'b1 : '0;
      if (w_nxt != r_state) r_timer <= '0;
      else if (w_stage)     r_timer <= r_timer + 1'b1;
      if (w_nxt == ST_RESTART && r_state != ST_RESTART && r_restart_cnt != '1)
        r_restart_cnt <= r_restart_cnt + 1'b1;
      // Reset outputs are registered from the next state so no input reaches an output combinationally
      if (w_nxt == ST_RESTART)          r_lane_rst <= '1;
      else if (w_nxt == ST_WAIT_SERDES) r_lane_rst <= ~serdes_lock_v_i;
      else                              r_lane_rst <= '0;
      r_deskew_rst <= (w_nxt == ST_RESTART) || (w_nxt == ST_WAIT_SERDES) ||
                      (w_nxt == ST_WAIT_BLOCK);
    end
  end

  assign lane_rst_o    = r_lane_rst;
  assign deskew_rst_o  = r_deskew_rst;
  assign link_up_o     = w_ber_en & ~w_hi_ber;
  assign hi_ber_o      = w_hi_ber;
  assign state_o       = r_state;
  assign restart_cnt_o = r_restart_cnt;

endmodule

// File: tb/tb_pcs_rx_link_ctrl.sv
// Directed bench for pcs_rx_link_ctrl with scaled-down timeouts and BER window.
module tb_pcs_rx_link_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] serdes, bs, am, hv, he, lane_rst;
  logic       deskew, deskew_rst, link_up, hi_ber;
  logic [2:0] state;
  logic [7:0] rcnt;
  int checks = 0, errors = 0, cyc = 0, exp_cnt = 0, L = 0, X = 0;

  pcs_rx_link_ctrl #(
    .LANE_N(4), .TIMER_W(20), .BLOCK_TO(64), .AM_TO(128), .DESKEW_TO(32),
    .RESTART_CYC(16), .BER_WIN(256), .HI_BER_CNT(4)
  ) dut (
    .clk(clk), .reset(reset), .serdes_lock_v_i(serdes), .bs_lock_v_i(bs),
    .am_lock_v_i(am), .deskew_lock_v_i(deskew), .head_v_i(hv), .head_err_i(he),
    .lane_rst_o(lane_rst), .deskew_rst_o(deskew_rst), .link_up_o(link_up),
    .hi_ber_o(hi_ber), .state_o(state), .restart_cnt_o(rcnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic to_cyc(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_st(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state !== s && n < budget) begin tick(); n++; end
    chk(tag, 32'(state), 32'(s));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_lane_rst"}, 32'(lane_rst), 4'hf);
    chk({tag, "_deskew_rst"}, 32'(deskew_rst), 1);
    chk({tag, "_link_up"}, 32'(link_up), 0);
    chk({tag, "_hi_ber"}, 32'(hi_ber), 0);
    chk({tag, "_rcnt"}, 32'(rcnt), 0);
  endtask

  initial begin
    reset = 1'b1; serdes = '0; bs = '0; am = '0; deskew = 1'b0; hv = '0; he = '0;
    // 1: bring-up with reset for two cycles
    to_cyc(1);  chk_reset_vals("rst");
    to_cyc(2);  reset = 1'b0;
    to_cyc(17); chk("restart_hold", 32'(state), 0);
    to_cyc(18); chk("wait_serdes", 32'(state), 1);
    chk("ws_lane_rst", 32'(lane_rst), 4'hf);
    to_cyc(20); serdes = 4'hf; tick();
    chk("lane_rst_fall21", 32'(lane_rst), 0);
    chk("wait_block21", 32'(state), 2);
    chk("wb_deskew_rst", 32'(deskew_rst), 1);
    to_cyc(40); bs = 4'hf; tick();
    chk("wait_am41", 32'(state), 3);
    chk("wa_deskew_rst", 32'(deskew_rst), 0);
    to_cyc(60); am = 4'hf; tick();
    chk("wait_deskew61", 32'(state), 4);
    to_cyc(70); chk("link_down70", 32'(link_up), 0);
    deskew = 1'b1; tick();
    chk("link_up71", 32'(link_up), 1);
    chk("state_up71", 32'(state), 5);
    chk("rcnt_bringup", 32'(rcnt), 0);

    // 3: single-cycle AM lock loss on lane 1
    to_cyc(75); am = 4'b1101; tick(); am = 4'hf; X = cyc;
    exp_cnt++;
    chk("loss_link_up", 32'(link_up), 0);
    chk("loss_state", 32'(state), 0);
    chk("loss_rcnt", 32'(rcnt), 32'(exp_cnt));

    // 2: lane 2 never block-locks -> timeout 64 cycles into WAIT_BLOCK
    bs = 4'b1011;
    to_cyc(X + 16); chk("to_ws_state", 32'(state), 1);
    chk("to_ws_lane_rst", 32'(lane_rst), 0);
    to_cyc(X + 80); chk("to_before", 32'(state), 2);
    to_cyc(X + 81); exp_cnt++;
    chk("to_state", 32'(state), 0);
    chk("to_lane_rst", 32'(lane_rst), 4'hf);
    chk("to_rcnt", 32'(rcnt), 32'(exp_cnt));
    to_cyc(X + 96); chk("to_hold_end", 32'(lane_rst), 4'hf);
    to_cyc(X + 97); chk("to_ws_again", 32'(state), 1);
    bs = 4'hf;
    wait_st(3'd5, 20, "relink");
    L = cyc;
    chk("relink_up", 32'(link_up), 1);

    // 4: BER monitor, errors on lanes 0 and 3 in two cycles
    to_cyc(L + 5); hv = 4'h0; he = 4'hf; tick(); he = 4'h0;
    chk("ber_nov_ignored", 32'(hi_ber), 0);
    to_cyc(L + 10); hv = 4'b1001; he = 4'b1001; tick();
    chk("ber_two", 32'(hi_ber), 0);
    tick(); hv = '0; he = '0;
    chk("ber_four", 32'(hi_ber), 1);
    chk("ber_link_mask", 32'(link_up), 0);
    chk("ber_state", 32'(state), 5);
`ifdef PCS_RX_LINK_CTRL_BER_RESTART_EN
    // 5: full bad window -> restart at wrap
    to_cyc(L + 255); chk("berrst_pre", 32'(state), 5);
    to_cyc(L + 256); exp_cnt++;
    chk("berrst_state", 32'(state), 0);
    chk("berrst_rcnt", 32'(rcnt), 32'(exp_cnt));
`else
    to_cyc(L + 256); chk("ber_wrap1_keep", 32'(hi_ber), 1);
    to_cyc(L + 511); chk("ber_wrap2_pre", 32'(hi_ber), 1);
    to_cyc(L + 512); chk("ber_clear", 32'(hi_ber), 0);
    chk("ber_clear_link", 32'(link_up), 1);
    // 5: errors again in window 3 -> flag stays through the wrap, no restart
    to_cyc(L + 520); hv = 4'b1001; he = 4'b1001; tick(); tick(); hv = '0; he = '0;
    chk("ber3_set", 32'(hi_ber), 1);
    to_cyc(L + 768);
    chk("ber3_stay_state", 32'(state), 5);
    chk("ber3_stay_flag", 32'(hi_ber), 1);
    chk("ber3_link", 32'(link_up), 0);
    deskew = 1'b0; tick(); deskew = 1'b1; exp_cnt++;
    chk("deskew_loss_state", 32'(state), 0);
    chk("deskew_loss_rcnt", 32'(rcnt), 32'(exp_cnt));
`endif

    // 6: saturate restart counter via serdes loss in WAIT_BLOCK
    for (int i = 0; i < 300; i++) begin
      wait_st(3'd2, 40, "sat_wb");
      serdes = 4'b0111; tick(); serdes = 4'hf;
      if (exp_cnt < 255) exp_cnt++;
      if (i == 0 || i == 299) chk("sat_rcnt", 32'(rcnt), 32'(exp_cnt));
    end
    chk("sat_255", 32'(rcnt), 255);
    am = 4'b1110;
    wait_st(3'd3, 40, "to_wait_am");
    reset = 1'b1; tick();
    chk_reset_vals("midrst");
    reset = 1'b0; am = 4'hf; tick();
    chk("post_rst_state", 32'(state), 0);
    chk("post_rst_rcnt", 32'(rcnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
